branch_update_queue: RTL and testbench
======================================

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of in-flight predicted branches; power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: push  input  1  fetch records one predicted conditional branch this cycle.
REQ-005 Port: push_pc  input  16  PC of the pushed branch.
REQ-006 Port: push_pred  input  1  predicted direction (1 = taken) read from the predictor for push_pc.
REQ-007 Port: resolve  input  1  execute resolves the oldest outstanding branch this cycle.
REQ-008 Port: resolve_taken  input  1  actual direction of the resolved branch.
REQ-009 Port: full  output  1  queue holds DEPTH entries.
REQ-010 Port: empty  output  1  queue holds 0 entries.
REQ-011 Port: count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 Port: pht_we  output  1  one-cycle predictor update strobe.
REQ-013 Port: pht_pc  output  16  PC to update in the predictor.
REQ-014 Port: pht_taken  output  1  actual outcome driven to the predictor.
REQ-015 Port: mispredict  output  1  one-cycle pulse: resolved outcome differed from stored prediction.
REQ-016 Ports (macro only): stat_branches, stat_mispredicts  output  16 each  event counters.

Function
REQ-017 The block SHALL be a circular FIFO of DEPTH entries {pc[15:0], pred}, with read/write pointers wrapping modulo DEPTH.
REQ-018 A push SHALL be accepted when !full, or when full and an accepted resolve occurs in the same cycle without mispredict.
REQ-019 A push while full and without an accepted resolve SHALL be ignored; state unchanged.
REQ-020 A resolve SHALL be accepted only when !empty; a resolve while empty SHALL be ignored with pht_we and mispredict held 0.
REQ-021 On an accepted resolve, at the next posedge: pht_we=1, pht_pc=head pc, pht_taken=resolve_taken, head popped; latency exactly 1 cycle.
REQ-022 On the same edge, mispredict SHALL equal (resolve_taken != head pred).
REQ-023 pht_we and mispredict SHALL be high for exactly one cycle per accepted resolve and 0 otherwise; pht_pc/pht_taken hold their last values when pht_we=0.
REQ-024 On a mispredicting resolve, all remaining entries SHALL be flushed (count->0, pointers equalised) and any push in that cycle discarded as wrong-path.
REQ-025 Simultaneous accepted push and non-mispredicting resolve SHALL leave count unchanged and write the new entry at the tail.
REQ-026 full, empty and count SHALL be derived from registered state only and be consistent every cycle.
REQ-027 All outputs SHALL change only on posedge clk, so a consumer sampling on negedge clk sees stable values.

Reset
REQ-028 While rst=0: pointers=0, count=0, empty=1, full=0, pht_we=0, pht_pc=16'h0000, pht_taken=0, mispredict=0, stat counters=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately with no update strobe issued for them.

Configuration
REQ-030 Macro BRANCH_UPDATE_STATS_EN SHALL compile in stat_branches (+1 per accepted resolve) and stat_mispredicts (+1 per mispredict), both saturating at 16'hFFFF.
REQ-031 Without BRANCH_UPDATE_STATS_EN the counters and their ports SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, push pc=16'h0010 pred=1, then resolve taken=1 -> next cycle pht_we=1, pht_pc=16'h0010, pht_taken=1, mispredict=0, empty=1.
REQ-033 Push 4 entries (DEPTH=4) -> full=1, count=4; 5th push alone ignored; push+resolve same cycle -> count stays 4, new entry at tail.
REQ-034 Push pcs 0x0020(pred 0), 0x0024, 0x0028; resolve taken=1 -> mispredict=1, pht_pc=16'h0020, count=0, concurrent push dropped.
REQ-035 Resolve with empty=1 -> pht_we=0, mispredict=0, count=0 over following cycles.
REQ-036 Push 6 then resolve 6 in order -> pht_pc sequence matches push order across pointer wrap.
REQ-037 With BRANCH_UPDATE_STATS_EN: 3 resolves, 1 mispredicted -> stat_branches=3, stat_mispredicts=1; rst=0 mid-stream clears both and count asynchronously.

Source files
------------

// File: rtl/branch_update_queue.sv
// branch_update_queue
//
// This queue holds predicted conditional branches from fetch until execute
// resolves them. Entries leave in order. Each resolve that the queue accepts
// sends a one-cycle update strobe to the pattern history table. A resolve
// whose outcome differs from the stored prediction also flushes every
// younger entry, because those entries were fetched down the wrong path.
//
// Parameters
//   DEPTH             number of in-flight entries (power of two, 2..16)
//
// Ports
//   clk               clock; all state changes on posedge
//   rst               asynchronous reset, active low
//   push              record a predicted branch this cycle
//   push_pc           PC of the pushed branch
//   push_pred         predicted direction of the pushed branch (1 = taken)
//   resolve           resolve the oldest outstanding branch this cycle
//   resolve_taken     actual direction of the resolved branch
//   full / empty      occupancy flags, taken from registered state
//   count             number of valid entries
//   pht_we            one-cycle predictor update strobe
//   pht_pc            PC to update; holds its value while pht_we is 0
//   pht_taken         actual outcome for the update; holds its value while pht_we is 0
//   mispredict        one-cycle pulse: the resolved outcome differed from the prediction
//
// Optional build macro BRANCH_UPDATE_STATS_EN adds two 16-bit counters that
// saturate at 16'hFFFF:
//   stat_branches     accepted resolves
//   stat_mispredicts  mispredicting resolves

module branch_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                push_pc,
    input  logic                       push_pred,
    input  logic                       resolve,
    input  logic                       resolve_taken,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       pht_we,
    output logic [15:0]                pht_pc,
    output logic                       pht_taken,
`ifdef BRANCH_UPDATE_STATS_EN
    output logic [15:0]                stat_branches,
    output logic [15:0]                stat_mispredicts,
`endif
    output logic                       mispredict
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [15:0]      mem_pc_q   [DEPTH];
    logic [15:0]      mem_pc_d   [DEPTH];
    logic [DEPTH-1:0] mem_pred_q;
    logic [DEPTH-1:0] mem_pred_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             pht_we_q, pht_we_d;
    logic [15:0]      pht_pc_q, pht_pc_d;
    logic             pht_taken_q, pht_taken_d;
    logic             mispredict_q, mispredict_d;

    logic             full_w;
    logic             empty_w;
    logic             res_acc;
    logic             mis_w;
    logic             push_acc;

    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    // A resolve needs an entry. A push is accepted when there is room, or
    // when a resolve in the same cycle frees the head entry. A push made in
    // the same cycle as a mispredicting resolve is on the wrong path, so it
    // is dropped.
    assign res_acc  = resolve && !empty_w;
    assign mis_w    = res_acc && (resolve_taken != mem_pred_q[rd_ptr_q]);
    assign push_acc = push && !mis_w && (!full_w || res_acc);

    always_comb begin
        mem_pc_d   = mem_pc_q;
        mem_pred_d = mem_pred_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (mis_w) begin
            // Flush: set the read pointer equal to the write pointer so that
            // every younger entry is discarded.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                mem_pc_d[wr_ptr_q]   = push_pc;
                mem_pred_d[wr_ptr_q] = push_pred;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (res_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_acc && !res_acc) begin
                count_d = count_q + 1'b1;
            end else if (!push_acc && res_acc) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_comb begin
        pht_we_d     = res_acc;
        mispredict_d = mis_w;
        pht_pc_d     = pht_pc_q;
        pht_taken_d  = pht_taken_q;
        if (res_acc) begin
            pht_pc_d    = mem_pc_q[rd_ptr_q];
            pht_taken_d = resolve_taken;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc_q[i] <= '0;
            end
            mem_pred_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pht_we_q     <= 1'b0;
            pht_pc_q     <= '0;
            pht_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            mem_pc_q     <= mem_pc_d;
            mem_pred_q   <= mem_pred_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pht_we_q     <= pht_we_d;
            pht_pc_q     <= pht_pc_d;
            pht_taken_q  <= pht_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign full       = full_w;
    assign empty      = empty_w;
    assign count      = count_q;
    assign pht_we     = pht_we_q;
    assign pht_pc     = pht_pc_q;
    assign pht_taken  = pht_taken_q;
    assign mispredict = mispredict_q;

`ifdef BRANCH_UPDATE_STATS_EN
    logic [15:0] stat_br_q, stat_br_d;
    logic [15:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (res_acc && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + 1'b1;
        end
        if (mis_w && (stat_mis_q != '1)) begin
            stat_mis_d = stat_mis_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
module tb_branch_update_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] push_pc;
    logic        push_pred;
    logic        resolve;
    logic        resolve_taken;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        pht_we;
    logic [15:0] pht_pc;
    logic        pht_taken;
    logic        mispredict;
`ifdef BRANCH_UPDATE_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int n_cmp;
    int n_err;

    branch_update_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_pc       (push_pc),
        .push_pred     (push_pred),
        .resolve       (resolve),
        .resolve_taken (resolve_taken),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .pht_we        (pht_we),
        .pht_pc        (pht_pc),
        .pht_taken     (pht_taken),
`ifdef BRANCH_UPDATE_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .mispredict    (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the posedge.
    task automatic cyc(input logic p, input logic [15:0] pc, input logic pr,
                       input logic r, input logic rt);
        push          = p;
        push_pc       = pc;
        push_pred     = pr;
        resolve       = r;
        resolve_taken = rt;
        @(posedge clk);
        #1;
        push    = 1'b0;
        resolve = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        push = 1'b0; push_pc = '0; push_pred = 1'b0;
        resolve = 1'b0; resolve_taken = 1'b0;

        // Values held during reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pht_we", 32'(pht_we), 32'd0);
        chk("rst_pht_pc", 32'(pht_pc), 32'h0000);
        chk("rst_pht_taken", 32'(pht_taken), 32'd0);
        chk("rst_mis", 32'(mispredict), 32'd0);
        rst = 1'b1;

        // A single push followed by a correctly predicted resolve
        cyc(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_empty0", 32'(empty), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t1_we", 32'(pht_we), 32'd1);
        chk("t1_pc", 32'(pht_pc), 32'h0010);
        chk("t1_taken", 32'(pht_taken), 32'd1);
        chk("t1_mis", 32'(mispredict), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t1_we_drop", 32'(pht_we), 32'd0);
        chk("t1_pc_hold", 32'(pht_pc), 32'h0010);
        chk("t1_taken_hold", 32'(pht_taken), 32'd1);

        // Fill the queue, push into a full queue, then push and resolve together
        cyc(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0104, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0108, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h010C, 1'b1, 1'b0, 1'b0);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count4", 32'(count), 32'd4);
        cyc(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
        chk("t2_ovf_count", 32'(count), 32'd4);
        chk("t2_ovf_we", 32'(pht_we), 32'd0);
        cyc(1'b1, 16'h0110, 1'b1, 1'b1, 1'b1);
        chk("t2_pr_pc", 32'(pht_pc), 32'h0100);
        chk("t2_pr_count", 32'(count), 32'd4);
        chk("t2_pr_full", 32'(full), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t2_d1", 32'(pht_pc), 32'h0104);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t2_d2", 32'(pht_pc), 32'h0108);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t2_d3", 32'(pht_pc), 32'h010C);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t2_d4_tail", 32'(pht_pc), 32'h0110);
        chk("t2_d4_empty", 32'(empty), 32'd1);

        // A mispredict flushes the queue and drops the push made in the same cycle
        cyc(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0024, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0028, 1'b1, 1'b0, 1'b0);
        chk("t3_count3", 32'(count), 32'd3);
        cyc(1'b1, 16'h002C, 1'b1, 1'b1, 1'b1);
        chk("t3_mis", 32'(mispredict), 32'd1);
        chk("t3_we", 32'(pht_we), 32'd1);
        chk("t3_pc", 32'(pht_pc), 32'h0020);
        chk("t3_taken", 32'(pht_taken), 32'd1);
        chk("t3_count0", 32'(count), 32'd0);
        chk("t3_empty", 32'(empty), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t3_mis_drop", 32'(mispredict), 32'd0);
        chk("t3_count_stay", 32'(count), 32'd0);

        // A resolve while the queue is empty is ignored
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("t5_we", 32'(pht_we), 32'd0);
        chk("t5_mis", 32'(mispredict), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t5_we2", 32'(pht_we), 32'd0);
        chk("t5_count2", 32'(count), 32'd0);

        // Six branches with mixed predictions, all resolved correctly, in
        // push order across the pointer wrap
        cyc(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0304, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0308, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h030C, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0310, 1'b0, 1'b1, 1'b0);
        chk("t4_r0", 32'(pht_pc), 32'h0300);
        cyc(1'b1, 16'h0314, 1'b1, 1'b1, 1'b1);
        chk("t4_r1", 32'(pht_pc), 32'h0304);
        chk("t4_r1_taken", 32'(pht_taken), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("t4_r2", 32'(pht_pc), 32'h0308);
        chk("t4_r2_taken", 32'(pht_taken), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t4_r3", 32'(pht_pc), 32'h030C);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("t4_r4", 32'(pht_pc), 32'h0310);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t4_r5", 32'(pht_pc), 32'h0314);
        chk("t4_r5_mis", 32'(mispredict), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);

        // Reset asserted in the middle of operation
        cyc(1'b1, 16'h0400, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0404, 1'b1, 1'b0, 1'b0);
        chk("t6_count2", 32'(count), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t6_no_strobe", 32'(pht_we), 32'd0);
        chk("t6_count_after", 32'(count), 32'd0);

`ifdef BRANCH_UPDATE_STATS_EN
        // Event counters: three resolves, the last one mispredicted
        chk("t7_stat_b0", 32'(stat_branches), 32'd0);
        cyc(1'b1, 16'h0500, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0504, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0508, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("t7_stat_b", 32'(stat_branches), 32'd3);
        chk("t7_stat_m", 32'(stat_mispredicts), 32'd1);
        cyc(1'b1, 16'h0600, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_b", 32'(stat_branches), 32'd0);
        chk("t7_rst_m", 32'(stat_mispredicts), 32'd0);
        chk("t7_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
